rotor0_forward_stage: RTL and testbench
=======================================

# rotor0_forward_stage

Forward (keyboard-to-reflector) path of rotor 0 with its own position register, stepping logic and turnover carry. Each accepted letter first steps the rotor, then is encoded through the rotor-I wiring at the new position. Output is registered behind a valid/ready handshake. The carry output drives stepping of the next rotor. This is the encode counterpart of the rotor-0 reverse path, and the two share the same position value.

## Interface
- `NOTCH`, default 16 (Q): the position whose departure raises `carry_out`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  load `load_pos` into the position register.
- `load_pos`  in  6  new position, 0..25.
- `in_valid`  in  1  input letter valid.
- `in_ready`  out  1  stage can accept a letter.
- `data_in`  in  6  letter code, 0=A .. 25=Z.
- `out_valid`  out  1  `data_out` holds an encoded letter.
- `out_ready`  in  1  downstream accepts.
- `data_out`  out  6  encoded letter.
- `err_out`  out  1  the letter in `data_out` was out of range.
- `carry_out`  out  1  one-cycle pulse when the rotor steps off `NOTCH`.
- `position`  out  6  current rotor position, exported to the reverse path.

## Operation
- Wiring, indexed 0..25: E K M F L G D Q V Z N T O W Y H X U S P A I B R C J.
  - As codes: 4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9.
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !load && (!out_valid || out_ready)`. This gives a single-entry output buffer.
- On accept with `data_in <= 25`:
  - `pos_n = (position==25) ? 0 : position+1`.
  - `idx = (data_in + pos_n) mod 26`.
  - `data_out <= wiring[idx]`, `err_out <= 0`, `position <= pos_n`.
- On accept with `data_in >= 26`:
  - `data_out <= 0`, `err_out <= 1`.
  - The position does not step and `carry_out` stays 0.
- `carry_out` pulses for one cycle, coincident with `out_valid` rising for that letter, when `position==NOTCH` before the step.
- Load:
  - `position <= (load_pos > 25) ? 0 : load_pos`.
  - Load has priority: `in_ready` is 0 in the load cycle.
  - An output already pending is unaffected.
- Mod-26 arithmetic: compute a 7-bit sum and subtract 26 if the sum is ≥ 26. No `%` operator.
- State is two phases, IDLE (`out_valid=0`) and HOLD (`out_valid=1`):
  - IDLE → HOLD on accept.
  - HOLD → IDLE on `out_ready` with no new accept.
  - HOLD → HOLD on a simultaneous drain and accept.
- Reset values: `position=0`, `data_out=0`, `err_out=0`, `out_valid=0`, `carry_out=0`. `in_ready` is 1 once reset deasserts.
- Reset asserted mid-operation discards any pending output.

## Timing
- Latency is 1 cycle, accept edge to `out_valid`.
- Throughput is 1 letter/cycle while `out_ready=1`.
- `data_out` and `err_out` are held stable while `out_valid && !out_ready`.
- A new `position` is visible on the cycle after the accept or load edge.
- `carry_out` is registered and high for exactly one cycle per turnover, even when the output stalls.

## Configuration
- Macro: `ROTOR0_RING_SETTING_EN`.
- Defined:
  - Adds port `ring  in  6`, the ring setting 0..25, sampled each accept.
  - `idx = (data_in + pos_n - ring) mod 26`, computed as `(data_in + pos_n + 26 - ring)` with conditional subtracts.
  - A `ring` value above 25 is treated as 0.
- Undefined: no `ring` port; behaves as `ring=0`.

## Structure
- Shared package `enigma_pkg` holds:
  - `LETTERS=26`.
  - `letter_t` (6-bit).
  - `ROTOR_I_FWD[26]` wiring constant, also used to derive the reverse path.
  - `ROTOR_I_NOTCH=16`.
- Sub-module `mod26_add`: combinational 6-bit + 6-bit mod-26 adder, instanced once for the step and once for the index. With the macro, a third instance performs the ring subtract.

## Test plan
- Reset, then `data_in=0`, `out_ready=1` → next cycle `out_valid=1`, `data_out=10` (K), `position=1`, `carry_out=0`.
- Load 16, then `data_in=0` → `data_out=20` (U), `position=17`, `carry_out=1` for one cycle.
- Load 25, then `data_in=3` → position wraps to 0, `data_out=5` (F).
- `data_in=30` → `err_out=1`, `data_out=0`, position unchanged, no carry.
- Hold `out_ready=0` after the first letter → `in_ready=0`, `data_out` stable. Release → the second letter is accepted the same cycle and output the next cycle.
- With `ROTOR0_RING_SETTING_EN`: `ring=1`, reset, `data_in=0` → `data_out=4` (E).

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, letter type, rotor-I forward wiring and notch.
// Forward wiring is the one table; the reverse path derives its inverse from it.
package enigma_pkg;

    localparam int LETTERS = 26;

    typedef logic [5:0] letter_t;

    localparam letter_t ROTOR_I_FWD [LETTERS] = '{
        6'd4,  6'd10, 6'd12, 6'd5,  6'd11, 6'd6,  6'd3,  6'd16, 6'd21,
        6'd25, 6'd13, 6'd19, 6'd14, 6'd22, 6'd24, 6'd7,  6'd23, 6'd20,
        6'd18, 6'd15, 6'd0,  6'd8,  6'd1,  6'd17, 6'd2,  6'd9
    };

    localparam int ROTOR_I_NOTCH = 16;

    // Out-of-range indices return 0 so the lookup never reads past the table.
    function automatic letter_t rotor_i_fwd(input letter_t idx);
        letter_t r;
        r = '0;
        for (int k = 0; k < LETTERS; k++) begin
            if (int'(idx) == k) r = ROTOR_I_FWD[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/rotor0_forward_stage_if.sv
// Letter stream into and out of the rotor-0 forward stage.
// master = environment driving letters in and draining results; slave = the stage.
interface rotor0_forward_stage_if;
    import enigma_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t data_in;
    logic    out_valid;
    logic    out_ready;
    letter_t data_out;
    logic    err_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, err_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, err_out
    );

endinterface

// File: rtl/rotor0_forward_stage_mod26_add.sv
// mod26_add: combinational (a + b) mod 26 for operands in 0..26, no divider.
// Latency 0; no handshake.
module mod26_add
    import enigma_pkg::*;
(
    input  letter_t a,
    input  letter_t b,
    output letter_t y
);

    logic [6:0] sum;
    logic [6:0] sum_wrap;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        sum_wrap = sum - 7'(LETTERS);
        y        = (sum >= 7'(LETTERS)) ? sum_wrap[5:0] : sum[5:0];
    end

endmodule

// File: rtl/rotor0_forward_stage.sv
// Rotor-0 forward path: steps on accept, encodes through rotor I, carries off NOTCH.
// Latency 1 cycle; single-entry output buffer, in_ready drops while stalled or loading.
// ROTOR0_RING_SETTING_EN adds a ring-setting input subtracted from the wiring index.
module rotor0_forward_stage
    import enigma_pkg::*;
#(
    parameter int NOTCH = ROTOR_I_NOTCH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  letter_t load_pos,
`ifdef ROTOR0_RING_SETTING_EN
    input  letter_t ring,
`endif
    rotor0_forward_stage_if.slave io,
    output logic    carry_out,
    output letter_t position
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t  state_q, state_d;
    letter_t position_q, position_d;
    letter_t data_q, data_d;
    logic    err_q, err_d;
    logic    carry_q, carry_d;

    letter_t pos_n;
    letter_t idx_raw;
    letter_t idx;
    logic    accept;
    logic    letter_ok;

    mod26_add u_step (.a(position_q), .b(6'd1),     .y(pos_n));
    mod26_add u_idx  (.a(io.data_in), .b(pos_n),    .y(idx_raw));

`ifdef ROTOR0_RING_SETTING_EN
    letter_t ring_s;
    letter_t ring_neg;
    always_comb begin
        ring_s   = (ring > 6'd25) ? 6'd0 : ring;
        ring_neg = (ring_s == 6'd0) ? 6'd0 : letter_t'(LETTERS) - ring_s;
    end
    mod26_add u_ring (.a(idx_raw), .b(ring_neg), .y(idx));
`else
    assign idx = idx_raw;
`endif

    always_comb begin
        io.in_ready = !load && ((state_q == IDLE) || io.out_ready);
        accept      = io.in_valid && io.in_ready;
        letter_ok   = (io.data_in <= 6'd25);

        state_d    = state_q;
        position_d = position_q;
        data_d     = data_q;
        err_d      = err_q;
        carry_d    = 1'b0;

        if (accept) begin
            state_d = HOLD;
            if (letter_ok) begin
                data_d     = rotor_i_fwd(idx);
                err_d      = 1'b0;
                position_d = pos_n;
                carry_d    = (position_q == letter_t'(NOTCH));
            end else begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end else if ((state_q == HOLD) && io.out_ready) begin
            state_d = IDLE;
        end

        // Load and accept are mutually exclusive since load forces in_ready low.
        if (load) position_d = (load_pos > 6'd25) ? 6'd0 : load_pos;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            position_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            data_q     <= data_d;
            err_q      <= err_d;
            carry_q    <= carry_d;
        end
    end

    assign io.out_valid = (state_q == HOLD);
    assign io.data_out  = data_q;
    assign io.err_out   = err_q;
    assign carry_out    = carry_q;
    assign position     = position_q;

endmodule

// File: tb/tb_rotor0_forward_stage.sv
// Directed bench for rotor0_forward_stage; expected letters hand-derived from rotor-I wiring.
module tb_rotor0_forward_stage;
    import enigma_pkg::*;

    logic    clk;
    logic    rst;
    logic    load;
    letter_t load_pos;
    logic    carry_out;
    letter_t position;
`ifdef ROTOR0_RING_SETTING_EN
    letter_t ring;
`endif

    int n_checks;
    int n_errors;

    rotor0_forward_stage_if io ();

    rotor0_forward_stage #(.NOTCH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_pos (load_pos),
`ifdef ROTOR0_RING_SETTING_EN
        .ring     (ring),
`endif
        .io       (io.slave),
        .carry_out(carry_out),
        .position (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input letter_t d);
        io.in_valid = 1'b1;
        io.data_in  = d;
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic out_is(input string tag, input logic v, input letter_t d, input logic e,
                          input letter_t p, input logic c);
        check({tag, ".valid"}, 32'(io.out_valid), 32'(v));
        check({tag, ".data"},  32'(io.data_out),  32'(d));
        check({tag, ".err"},   32'(io.err_out),   32'(e));
        check({tag, ".pos"},   32'(position),     32'(p));
        check({tag, ".carry"}, 32'(carry_out),    32'(c));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        load         = 1'b0;
        load_pos     = '0;
        io.in_valid  = 1'b0;
        io.data_in   = '0;
        io.out_ready = 1'b1;
`ifdef ROTOR0_RING_SETTING_EN
        ring         = '0;
`endif
        #12;
        out_is("reset", 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        rst = 1'b0;
        #1;
        check("reset.in_ready", 32'(io.in_ready), 32'd1);

        // A at pos 0 -> steps to 1, wiring[1] = K
        send(6'd0);
        out_is("first", 1'b1, 6'd10, 1'b0, 6'd1, 1'b0);
        tick();
        check("drain.valid", 32'(io.out_valid), 32'd0);

        // Load wins over a concurrent letter; the letter is taken next cycle
        load = 1'b1; load_pos = 6'd16;
        io.in_valid = 1'b1; io.data_in = 6'd0;
        #1;
        check("load.in_ready", 32'(io.in_ready), 32'd0);
        tick();
        load = 1'b0;
        check("load.pos", 32'(position), 32'd16);
        check("load.no_accept", 32'(io.out_valid), 32'd0);
        tick();
        io.in_valid = 1'b0;
        out_is("notch", 1'b1, 6'd20, 1'b0, 6'd17, 1'b1);
        tick();
        check("notch.pulse_end", 32'(carry_out), 32'd0);

        // Position 25 wraps to 0, D -> wiring[3] = F
        load = 1'b1; load_pos = 6'd25;
        tick();
        load = 1'b0;
        send(6'd3);
        out_is("wrap", 1'b1, 6'd5, 1'b0, 6'd0, 1'b0);

        send(6'd30);
        out_is("bad_letter", 1'b1, 6'd0, 1'b1, 6'd0, 1'b0);
        tick();

        // Stall: second letter waits until out_ready returns
        io.out_ready = 1'b0;
        send(6'd0);
        out_is("stall1", 1'b1, 6'd10, 1'b0, 6'd1, 1'b0);
        io.in_valid = 1'b1; io.data_in = 6'd1;
        #1;
        check("stall.in_ready", 32'(io.in_ready), 32'd0);
        tick();
        out_is("stall.hold", 1'b1, 6'd10, 1'b0, 6'd1, 1'b0);
        io.out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(io.in_ready), 32'd1);
        tick();
        io.in_valid = 1'b0;
        out_is("release", 1'b1, 6'd5, 1'b0, 6'd2, 1'b0);
        tick();
        check("release.drain", 32'(io.out_valid), 32'd0);

        // Carry stays one cycle even while the output stalls
        load = 1'b1; load_pos = 6'd16;
        tick();
        load = 1'b0;
        io.out_ready = 1'b0;
        send(6'd5);
        out_is("carry_stall", 1'b1, 6'd1, 1'b0, 6'd17, 1'b1);
        tick();
        out_is("carry_stall2", 1'b1, 6'd1, 1'b0, 6'd17, 1'b0);

        // Out-of-range load clamps to 0 and leaves the pending output alone
        load = 1'b1; load_pos = 6'd40;
        tick();
        load = 1'b0;
        out_is("load_pending", 1'b1, 6'd1, 1'b0, 6'd0, 1'b0);
        io.out_ready = 1'b1;
        tick();
        check("load_pending.drain", 32'(io.out_valid), 32'd0);

        // Back-to-back letters at full rate
        io.in_valid = 1'b1; io.data_in = 6'd0;
        tick();
        out_is("burst0", 1'b1, 6'd10, 1'b0, 6'd1, 1'b0);
        io.data_in = 6'd2;
        tick();
        out_is("burst1", 1'b1, 6'd11, 1'b0, 6'd2, 1'b0);
        io.data_in = 6'd25;
        tick();
        io.in_valid = 1'b0;
        out_is("burst2", 1'b1, 6'd12, 1'b0, 6'd3, 1'b0);
        tick();

        // Reset mid-operation discards the pending letter
        io.out_ready = 1'b0;
        send(6'd0);
        check("pre_rst.valid", 32'(io.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        out_is("mid_rst", 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        tick();
        rst = 1'b0;
        io.out_ready = 1'b1;

`ifdef ROTOR0_RING_SETTING_EN
        ring = 6'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(6'd0);
        out_is("ring1", 1'b1, 6'd4, 1'b0, 6'd1, 1'b0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
